// File: rtl/simd_pe_array.sv
// SIMD lane array: lane-wise ADD/SUB/MUL into s1_reg, plus a dot-product tree reduction into s2_reg.
// Build option: define PE_SATURATE_EN for signed-saturating ADD/SUB (MUL and reductions always wrap).
module simd_pe_lane #(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]          sel,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] res
);
  localparam int MSB = DATA_LEN - 1;
  localparam logic [DATA_LEN-1:0] SMAX = {1'b0, {MSB{1'b1}}};
  localparam logic [DATA_LEN-1:0] SMIN = {1'b1, {MSB{1'b0}}};

  logic [DATA_LEN-1:0] sum, diff, prod;
  assign sum  = a + b;
  assign diff = a - b;
  assign prod = a * b;

`ifdef PE_SATURATE_EN
  logic ovf_add, ovf_sub;
  // Overflow only when the result sign disagrees with what the operand signs allow.
  assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  always_comb begin
    res = prod;
    case (sel)
      2'd0:    res = ovf_add ? (a[MSB] ? SMIN : SMAX) : sum;
      2'd1:    res = ovf_sub ? (a[MSB] ? SMIN : SMAX) : diff;
      default: res = prod;
    endcase
  end
`else
  always_comb begin
    res = prod;
    case (sel)
      2'd0:    res = sum;
      2'd1:    res = diff;
      default: res = prod;
    endcase
  end
`endif
endmodule

module simd_pe_array #(
  parameter int DATA_LEN      = 32,
  parameter int PE_ELEMENTS   = 4,
  parameter int PE_OPCODE_LEN = 3
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [PE_OPCODE_LEN-1:0]                 pe_opcode,
  input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]     data_a,
  input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]     data_b,
  output logic [DATA_LEN*PE_ELEMENTS-1:0]          pe_stage_1_output,
  output logic                                     pe_stage_1_valid,
  output logic [DATA_LEN-1:0]                      pe_stage_2_output,
  output logic                                     pe_stage_2_valid,
  output logic                                     store_result,
  output logic                                     busy
);
  localparam int LOG = $clog2(PE_ELEMENTS);
  localparam logic [LOG-1:0] LAST = LOG'(LOG - 1);

  localparam logic [PE_OPCODE_LEN-1:0] OP_ADD     = PE_OPCODE_LEN'(1);
  localparam logic [PE_OPCODE_LEN-1:0] OP_SUB     = PE_OPCODE_LEN'(2);
  localparam logic [PE_OPCODE_LEN-1:0] OP_MUL     = PE_OPCODE_LEN'(3);
  localparam logic [PE_OPCODE_LEN-1:0] OP_DOTP    = PE_OPCODE_LEN'(4);
  localparam logic [PE_OPCODE_LEN-1:0] OP_EMIT_S1 = PE_OPCODE_LEN'(5);
  localparam logic [PE_OPCODE_LEN-1:0] OP_EMIT_S2 = PE_OPCODE_LEN'(6);
  localparam logic [PE_OPCODE_LEN-1:0] OP_STORE   = PE_OPCODE_LEN'(7);

  typedef enum logic {IDLE, REDUCE} state_t;

  state_t                                state;
  logic [LOG-1:0]                        cnt;
  logic                                  pending;
  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]  s1_reg, work, work_nxt, lane_res;
  logic [DATA_LEN-1:0]                   s2_reg;
  logic [1:0]                            lane_sel;
  logic                                  lane_wr;

  assign lane_sel = (pe_opcode == OP_ADD) ? 2'd0 : (pe_opcode == OP_SUB) ? 2'd1 : 2'd2;
  assign lane_wr  = (pe_opcode == OP_ADD) || (pe_opcode == OP_SUB) ||
                    (pe_opcode == OP_MUL) || (pe_opcode == OP_DOTP);

  for (genvar g = 0; g < PE_ELEMENTS; g++) begin : g_lane
    simd_pe_lane #(.DATA_LEN(DATA_LEN)) u_lane (
      .sel(lane_sel), .a(data_a[g]), .b(data_b[g]), .res(lane_res[g])
    );
  end

  // One tree level per cycle: pair sums pack into the low half, upper lanes zero.
  always_comb begin
    work_nxt = '0;
    for (int i = 0; i < PE_ELEMENTS / 2; i++)
      work_nxt[i] = work[2*i] + work[2*i+1];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= IDLE;
      cnt              <= '0;
      pending          <= 1'b0;
      s1_reg           <= '0;
      s2_reg           <= '0;
      work             <= '0;
      pe_stage_1_valid <= 1'b0;
      pe_stage_2_valid <= 1'b0;
      store_result     <= 1'b0;
    end else begin
      pe_stage_1_valid <= (pe_opcode == OP_EMIT_S1);
      store_result     <= (pe_opcode == OP_STORE);
      pe_stage_2_valid <= 1'b0;
      if (lane_wr) s1_reg <= lane_res;
      if (pe_opcode == OP_DOTP) begin
        // Restart discards any in-flight sum; a pending emit waits for the new one.
        work  <= lane_res;
        cnt   <= '0;
        state <= REDUCE;
      end else if (state == REDUCE) begin
        work <= work_nxt;
        cnt  <= cnt + LOG'(1);
        if (cnt == LAST) begin
          state            <= IDLE;
          s2_reg           <= work_nxt[0];
          pe_stage_2_valid <= pending || (pe_opcode == OP_EMIT_S2);
          pending          <= 1'b0;
        end else if (pe_opcode == OP_EMIT_S2) begin
          pending <= 1'b1;
        end
      end else if (pe_opcode == OP_EMIT_S2) begin
        pe_stage_2_valid <= 1'b1;
      end
    end
  end

  assign pe_stage_1_output = s1_reg;
  assign pe_stage_2_output = s2_reg;
  assign busy              = (state == REDUCE);
endmodule

// File: tb/tb_simd_pe_array.sv
// Scoreboard bench for simd_pe_array: stimulus queues expected pulses, a negedge monitor checks them.
module tb_simd_pe_array;
  localparam int DL = 32, N = 4, OW = 3, W = DL * N;
  typedef logic [N-1:0][DL-1:0] vec_t;
  typedef struct { int cyc; logic [W-1:0] d; } exp_t;

  localparam logic [OW-1:0] NOOP = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                            DOTP = 3'd4, EMIT_S1 = 3'd5, EMIT_S2 = 3'd6, STORE = 3'd7;

  logic          clk = 1'b0, rstn = 1'b0;
  logic [OW-1:0] opcode = EMIT_S1;
  vec_t          da = '0, db = '0;
  logic [W-1:0]  s1o;
  logic [DL-1:0] s2o;
  logic          s1v, s2v, store, busy;

  int cyc = 0, icyc = 0, vectors = 0, miscompares = 0;
  bit running = 1'b0;
  exp_t q1[$], q2[$];
  int   qs[$];

  vec_t A    = {32'd4, 32'd3, 32'd2, 32'd1};
  vec_t B    = {32'd8, 32'd7, 32'd6, 32'd5};
  vec_t ONES = {32'd1, 32'd1, 32'd1, 32'd1};
  vec_t TWOS = {32'd2, 32'd2, 32'd2, 32'd2};
  vec_t SA   = {32'd0, 32'd5,  32'h80000000, 32'h7FFFFFFF};
  vec_t SB   = {32'd0, 32'd3,  32'hFFFFFFFF, 32'h00000001};
  vec_t TA   = {32'd0, 32'd10, 32'h7FFFFFFF, 32'h80000000};
  vec_t TB   = {32'd0, 32'd3,  32'hFFFFFFFF, 32'h00000001};
`ifdef PE_SATURATE_EN
  vec_t ADDX = {32'd0, 32'd8, 32'h80000000, 32'h7FFFFFFF};
  vec_t SUBX = {32'd0, 32'd7, 32'h7FFFFFFF, 32'h80000000};
`else
  vec_t ADDX = {32'd0, 32'd8, 32'h7FFFFFFF, 32'h80000000};
  vec_t SUBX = {32'd0, 32'd7, 32'h80000000, 32'h7FFFFFFF};
`endif

  simd_pe_array #(.DATA_LEN(DL), .PE_ELEMENTS(N), .PE_OPCODE_LEN(OW)) dut (
    .clk(clk), .rstn(rstn), .pe_opcode(opcode), .data_a(da), .data_b(db),
    .pe_stage_1_output(s1o), .pe_stage_1_valid(s1v),
    .pe_stage_2_output(s2o), .pe_stage_2_valid(s2v),
    .store_result(store), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [W-1:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected pulse at cycle %0d carrying %h", name, cyc, act);
  endtask

  task automatic issue(input logic [OW-1:0] op, input vec_t a, input vec_t b);
    @(negedge clk);
    opcode = op; da = a; db = b; icyc = cyc;
  endtask

  task automatic op1(input logic [OW-1:0] op);
    @(negedge clk);
    opcode = op; icyc = cyc;
  endtask

  task automatic exp_s1(input int c, input vec_t v);
    exp_t e;
    e.cyc = c; e.d = v;
    q1.push_back(e);
  endtask

  task automatic exp_s2(input int c, input logic [DL-1:0] v);
    exp_t e;
    e.cyc = c; e.d = W'(v);
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (running) begin
      if (s1v) begin
        if (q1.size() == 0) unexpected("s1_pulse", s1o);
        else begin
          e = q1.pop_front();
          chk("s1_cycle", W'(cyc), W'(e.cyc));
          chk("s1_data", s1o, e.d);
        end
      end
      if (s2v) begin
        if (q2.size() == 0) unexpected("s2_pulse", W'(s2o));
        else begin
          e = q2.pop_front();
          chk("s2_cycle", W'(cyc), W'(e.cyc));
          chk("s2_data", W'(s2o), e.d);
        end
      end
      if (store) begin
        if (qs.size() == 0) unexpected("store_pulse", '0);
        else chk("store_cycle", W'(cyc), W'(qs.pop_front()));
      end
    end
  end

  initial begin
    // Reset held across two edges with an emit opcode that must be ignored.
    @(negedge clk);
    running = 1'b1;
    chk("rst_s1", s1o, '0);
    chk("rst_s2", W'(s2o), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_pulses", W'({s1v, s2v, store}), '0);
    @(negedge clk);
    rstn = 1'b1; opcode = NOOP;

    issue(ADD, A, B);  op1(EMIT_S1); exp_s1(icyc + 1, {32'd12, 32'd10, 32'd8, 32'd6});
    issue(SUB, A, B);  op1(EMIT_S1); exp_s1(icyc + 1, {4{32'hFFFFFFFC}});
    issue(MUL, A, B);  op1(EMIT_S1); exp_s1(icyc + 1, {32'd32, 32'd21, 32'd12, 32'd5});

    // Dot product 1*5+2*6+3*7+4*8 = 70, pending emit.
    issue(DOTP, A, B); exp_s2(icyc + 3, 32'd70);
    op1(EMIT_S2); chk("dotp_busy_c1", W'(busy), W'(1));
    op1(NOOP);    chk("dotp_busy_c2", W'(busy), W'(1));
    op1(NOOP);    chk("dotp_busy_c3", W'(busy), W'(0));
    op1(EMIT_S1); exp_s1(icyc + 1, {32'd32, 32'd21, 32'd12, 32'd5});
    op1(EMIT_S2); exp_s2(icyc + 1, 32'd70);

    // Restart: 8 is aborted, only 10 is reported despite repeated emits.
    issue(DOTP, ONES, TWOS);
    issue(DOTP, A, ONES); exp_s2(icyc + 3, 32'd10);
    op1(EMIT_S2); op1(EMIT_S2); op1(NOOP); op1(NOOP);

    // Lane op during reduction: 2*(5+6+7+8) = 52, s1 becomes 1+2.
    issue(DOTP, TWOS, B); exp_s2(icyc + 3, 32'd52);
    issue(ADD, ONES, TWOS); op1(EMIT_S2);
    op1(EMIT_S1); exp_s1(icyc + 1, {4{32'd3}});

    issue(ADD, SA, SB); op1(EMIT_S1); exp_s1(icyc + 1, ADDX);
    issue(SUB, TA, TB); op1(EMIT_S1); exp_s1(icyc + 1, SUBX);

    op1(STORE); qs.push_back(icyc + 1);
    op1(NOOP); op1(NOOP); op1(NOOP);
    op1(EMIT_S1); exp_s1(icyc + 1, SUBX);
    op1(EMIT_S2); exp_s2(icyc + 1, 32'd52);

    // Reset mid-reduction discards the sum.
    issue(DOTP, A, B);
    @(negedge clk); rstn = 1'b0; opcode = NOOP;
    @(negedge clk); rstn = 1'b1;
    chk("rstmid_busy", W'(busy), '0);
    chk("rstmid_s2", W'(s2o), '0);
    op1(EMIT_S2); exp_s2(icyc + 1, 32'd0);
    op1(EMIT_S1); exp_s1(icyc + 1, '0);
    repeat (4) op1(NOOP);

    chk("queue_drain", W'(q1.size() + q2.size() + qs.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
